// File: rtl/instruction_fetcher.sv
// Instruction fetcher with a small direct-mapped instruction cache.
// Hits return in one cycle; misses issue a program-memory read and fill the line.
module instruction_fetcher #(
  parameter int PROGRAM_MEM_ADDR_BITS = 8,
  parameter int PROGRAM_MEM_DATA_BITS = 16,
  parameter int CACHE_LINES           = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [2:0]                       core_state,
  input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
  input  logic                             invalidate,
  output logic                             mem_read_valid,
  output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
  input  logic                             mem_read_ready,
  input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data,
  output logic [2:0]                       fetcher_state,
  output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction,
  output logic [15:0]                      hit_count
);

  localparam int AW = PROGRAM_MEM_ADDR_BITS;
  localparam int DW = PROGRAM_MEM_DATA_BITS;
  localparam int IW = $clog2(CACHE_LINES);
  localparam int TW = AW - IW;

  localparam logic [2:0] CORE_FETCH  = 3'b001;
  localparam logic [2:0] CORE_DECODE = 3'b010;

  typedef enum logic [2:0] {
    S_IDLE     = 3'b000,
    S_FETCHING = 3'b001,
    S_FETCHED  = 3'b010
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [AW-1:0]    r_addr;
  logic [DW-1:0]    r_instr;
  logic [15:0]      r_hits;
  logic [CACHE_LINES-1:0] r_valid;
  logic [TW-1:0]    r_tag  [CACHE_LINES];
  logic [DW-1:0]    r_data [CACHE_LINES];

  logic [IW-1:0]    w_pc_idx;
  logic [TW-1:0]    w_pc_tag;
  logic [IW-1:0]    w_fill_idx;
  logic [TW-1:0]    w_fill_tag;
  logic             w_lookup;
  logic             w_hit;
  logic             w_miss;
  logic             w_fill;

  assign w_pc_idx   = current_pc[IW-1:0];
  assign w_pc_tag   = current_pc[AW-1:IW];
  assign w_fill_idx = r_addr[IW-1:0];
  assign w_fill_tag = r_addr[AW-1:IW];
  assign w_lookup   = (r_state == S_IDLE) && (core_state == CORE_FETCH);
  assign w_hit      = w_lookup && r_valid[w_pc_idx]
                      && (r_tag[w_pc_idx] == w_pc_tag);
  assign w_miss     = w_lookup && !w_hit;
  assign w_fill     = (r_state == S_FETCHING) && mem_read_ready;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state decode
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_hit)       w_next = S_FETCHED;
        else if (w_miss) w_next = S_FETCHING;
      end
      S_FETCHING: if (mem_read_ready) w_next = S_FETCHED;
      S_FETCHED:  if (core_state == CORE_DECODE) w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  // Outputs; the request is live exactly while a miss is outstanding
  always_comb begin
    mem_read_valid   = (r_state == S_FETCHING);
    mem_read_address = r_addr;
    fetcher_state    = r_state;
    instruction      = r_instr;
    hit_count        = r_hits;
  end

  // Request address, instruction and hit counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_addr  <= '0;
      r_instr <= '0;
      r_hits  <= '0;
    end else begin
      if (w_miss) r_addr <= current_pc;
      if (w_hit) begin
        r_instr <= r_data[w_pc_idx];
        if (r_hits != 16'hFFFF) r_hits <= r_hits + 16'd1;
      end
      if (w_fill) r_instr <= mem_read_data;
    end
  end

  // Valid bits; invalidate beats a same-edge fill
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          r_valid <= '0;
    else if (invalidate) r_valid <= '0;
    else if (w_fill)     r_valid[w_fill_idx] <= 1'b1;
  end

  // Tag and data arrays need no reset; the valid bits gate them
  always_ff @(posedge clk) begin
    if (w_fill) begin
      r_tag[w_fill_idx]  <= w_fill_tag;
      r_data[w_fill_idx] <= mem_read_data;
    end
  end

endmodule
